down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
- Synchronous, loadable down-counting timer. It is the counterpart to the team's free-running ripple up-counter.
- It counts down from a programmed value and reports terminal count via a one-cycle pulse and a sticky done flag.
- Supports pause, abort, restart and auto-reload. With auto-reload and a load value of 2^WIDTH-1 it behaves as a free-running synchronous mod-2^WIDTH down counter.
- It is a general event/timeout timer for control blocks in the same design.

Parameters:
- WIDTH, 4, counter and load-value width in bits.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous reset, active-high.
- load_val  input  WIDTH  start value, sampled only on the edge where start is accepted.
- start  input  1  start/restart request; sampled each posedge.
- stop  input  1  abort request; returns the block to IDLE.
- pause  input  1  holds count while asserted in RUN.
- auto_reload  input  1  when 1 at the zero-reaching edge, the timer reloads instead of finishing.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  1 while in RUN (including while paused).
- tc  output  1  terminal-count pulse, exactly one cycle, coincident with count==0 in RUN.
- done  output  1  sticky, 1 in DONE state.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high; it is sampled only on posedge clk.
- Reset: state=IDLE, count=0, busy=0, tc=0, done=0, internal reload register=0. Reset has priority over every other input, including mid-count.
- States:
  - IDLE: count holds 0.
  - RUN: counting.
  - DONE: finished, count=0, done=1.
- Edge priority (highest first): rst > stop > start > pause > decrement.
- stop (any state): next state IDLE; count=0, busy=0, done=0, tc=0.
- Start from any state (no stop): reload_reg<=load_val, count<=load_val, state<=RUN, busy<=1, done<=0, tc<=0.
  - start in RUN restarts immediately with the new load_val, discarding the current count.
  - load_val==0: next state RUN but count is already 0. This is handled as a zero-reaching event on the following edge (see below), so tc asserts one cycle after count shows 0.
- RUN decrement rules:
  - pause=1: count, tc=0 and state hold.
  - pause=0 and count>1: count<=count-1, tc<=0.
  - pause=0 and count==1 (zero-reaching edge): count<=0, tc<=1.
    - If auto_reload=1: stay in RUN.
    - Else: state<=DONE, busy<=0, done<=1.
  - pause=0 and count==0 (only after a reload-pending zero or load 0):
    - If tc was 1 last cycle and auto_reload=1: count<=reload_reg, tc<=0.
    - If load 0 path: tc<=1, then DONE, or stay in RUN with reload if auto_reload.
- Latency: start accepted at edge k gives count=N at k+1. Count reaches 0 with tc=1 after N further unpaused edges.
- Auto-reload period is N+1 unpaused cycles (N..0 inclusive). A paused cycle extends the period by one.
- auto_reload is a live input, sampled only at the zero-reaching edge and the reload edge.
- DONE: count=0, done=1, busy=0, tc=0 after the pulse cycle. Holds until start, stop or rst.
- Arithmetic: unsigned, WIDTH bits. count never underflows; no wrap below 0 ever occurs.
- tc is never asserted outside RUN-derived zero events, and never for two consecutive cycles unless load_val==0 with auto_reload=1. In that case tc is asserted every cycle, which is defined behaviour.

Test Plan:
1. rst=1 for 3 cycles while start=1, load_val=9 -> count=0, busy=0, tc=0, done=0 throughout. Release rst, start=1 one cycle -> next cycle count=9, busy=1.
2. load_val=5, auto_reload=0, single start pulse -> count 5,4,3,2,1,0. tc=1 only on the count=0 cycle, with busy falling and done rising that same cycle. done stays 1 for 10 idle cycles.
3. load_val=15, auto_reload=1, run 40 cycles -> count sequence 15..0 repeating with period 16. tc pulses exactly 2 times (16 cycles apart); busy stays 1; done stays 0.
4. load_val=6, assert pause for 3 cycles when count=4 -> count holds 4 for 3 cycles. tc occurs 3 cycles later than in the unpaused run (9 vs 6 cycles after count=6).
5. Mid-count events, load_val=8:
   - stop at count=3 -> next cycle IDLE, count=0, busy=0, no tc.
   - Repeat, but start with load_val=2 at count=5 -> count=2 next, then 1, 0 with tc.
   - Repeat, but rst at count=4 -> all outputs 0 next cycle.
6. load_val=0, start, auto_reload=0 -> count=0 with busy=1 one cycle, then tc=1 and done=1 the following cycle. Simultaneous stop+start at the same edge -> stop wins: IDLE, count=0.

Source files
------------

// File: rtl/down_timer_if.sv
// Control/status bundle for down_timer.
// The master side drives the load value and the control requests.
// The slave side (the timer) drives count and the status flags.
interface down_timer_if #(
  parameter int unsigned WIDTH = 4
) ();

  // Control requests and the start value, sampled by the timer on posedge clk.
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;

  // Registered status produced by the timer.
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output load_val,
    output start,
    output stop,
    output pause,
    output auto_reload,
    input  count,
    input  busy,
    input  tc,
    input  done
  );

  modport slave (
    input  load_val,
    input  start,
    input  stop,
    input  pause,
    input  auto_reload,
    output count,
    output busy,
    output tc,
    output done
  );

endinterface

// File: rtl/down_timer.sv
// Loadable synchronous down-counting timer with pause, abort, restart and
// auto-reload. tc pulses for one cycle on each zero event; done is sticky
// while the timer sits in DONE.
module down_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  down_timer_if.slave  tmr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q,     tc_d;
  logic             done_q,   done_d;
  logic             busy_q,   busy_d;
  // Set when a zero event left the timer in RUN for an auto-reload; the next
  // unpaused edge reloads instead of raising another tc. Kept separate from
  // tc_q so a pause on the zero cycle does not turn the reload into a new
  // zero event.
  logic             pend_q,   pend_d;

  logic             zero_evt;

  // A zero event: count steps 1->0, or count already sits at 0 in RUN
  // (load of 0), or a reload of 0 with auto_reload still set.
  always_comb begin
    zero_evt = 1'b0;
    if (count_q == CNT_ONE) begin
      zero_evt = 1'b1;
    end else if (count_q == '0) begin
      zero_evt = !pend_q || (tmr.auto_reload && (reload_q == '0));
    end
  end

  // Next-state logic, priority stop > start > pause > decrement.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    done_d   = done_q;
    pend_d   = pend_q;

    if (tmr.stop) begin
      state_d = ST_IDLE;
      count_d = '0;
      done_d  = 1'b0;
      pend_d  = 1'b0;
    end else if (tmr.start) begin
      state_d  = ST_RUN;
      count_d  = tmr.load_val;
      reload_d = tmr.load_val;
      done_d   = 1'b0;
      pend_d   = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!tmr.pause) begin
            if (zero_evt) begin
              count_d = '0;
              tc_d    = 1'b1;
              if (tmr.auto_reload) begin
                pend_d = 1'b1;
              end else begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                pend_d  = 1'b0;
              end
            end else if (count_q == '0) begin
              // Reload edge following an auto-reload zero event.
              if (tmr.auto_reload) begin
                count_d = reload_q;
                pend_d  = 1'b0;
              end else begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                pend_d  = 1'b0;
              end
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end
        end
        ST_DONE: begin
          count_d = '0;
          done_d  = 1'b1;
          pend_d  = 1'b0;
        end
        ST_IDLE: begin
          count_d = '0;
          done_d  = 1'b0;
          pend_d  = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
          done_d  = 1'b0;
          pend_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      pend_q   <= pend_d;
    end
  end

  assign tmr.count = count_q;
  assign tmr.busy  = busy_q;
  assign tmr.tc    = tc_q;
  assign tmr.done  = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer with hand-computed expected values.
module tb_down_timer;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int unsigned n_chk;
  int unsigned n_err;

  down_timer_if #(.WIDTH(W)) tmr ();

  down_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (tmr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Compares {count,busy,tc,done} as one packed value.
  task automatic expect_st(input string tag, input int unsigned c, input logic b,
                           input logic t, input logic d);
    logic [W-1:0] cv;
    cv = c[W-1:0];
    check_eq(tag, 32'({tmr.count, tmr.busy, tmr.tc, tmr.done}), 32'({cv, b, t, d}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned tc_seen;
    int unsigned exp_c;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    tmr.load_val = '0;
    tmr.start = 1'b0;
    tmr.stop = 1'b0;
    tmr.pause = 1'b0;
    tmr.auto_reload = 1'b0;

    // 1: reset dominates start
    tmr.start = 1'b1;
    tmr.load_val = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_st("reset_hold", 0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    tick();
    expect_st("start_9", 9, 1'b1, 1'b0, 1'b0);
    tmr.start = 1'b0;
    tmr.stop = 1'b1;
    tick();
    expect_st("stop_9", 0, 1'b0, 1'b0, 1'b0);
    tmr.stop = 1'b0;

    // 2: one-shot from 5
    tmr.load_val = 4'd5;
    tmr.start = 1'b1;
    tick();
    expect_st("os_5", 5, 1'b1, 1'b0, 1'b0);
    tmr.start = 1'b0;
    for (int unsigned v = 4; v >= 1; v--) begin
      tick();
      expect_st("os_dec", v, 1'b1, 1'b0, 1'b0);
    end
    tick();
    expect_st("os_tc", 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_st("os_done_hold", 0, 1'b0, 1'b0, 1'b1);
    end

    // 3: free-running mod-16 with auto-reload
    tmr.load_val = 4'd15;
    tmr.auto_reload = 1'b1;
    tmr.start = 1'b1;
    tick();
    expect_st("ar_15", 15, 1'b1, 1'b0, 1'b0);
    tmr.start = 1'b0;
    tc_seen = 0;
    for (int unsigned j = 1; j < 40; j++) begin
      tick();
      exp_c = 15 - (j % 16);
      expect_st("ar_seq", exp_c, 1'b1, (exp_c == 0), 1'b0);
      if (tmr.tc) tc_seen++;
    end
    check_eq("ar_tc_count", tc_seen, 32'd2);
    tmr.stop = 1'b1;
    tick();
    expect_st("ar_stop", 0, 1'b0, 1'b0, 1'b0);
    tmr.stop = 1'b0;
    tmr.auto_reload = 1'b0;

    // 4: pause for 3 cycles at count 4
    tmr.load_val = 4'd6;
    tmr.start = 1'b1;
    tick();
    expect_st("pz_6", 6, 1'b1, 1'b0, 1'b0);
    tmr.start = 1'b0;
    tick();
    expect_st("pz_5", 5, 1'b1, 1'b0, 1'b0);
    tick();
    expect_st("pz_4", 4, 1'b1, 1'b0, 1'b0);
    tmr.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_st("pz_hold", 4, 1'b1, 1'b0, 1'b0);
    end
    tmr.pause = 1'b0;
    for (int unsigned v = 3; v >= 1; v--) begin
      tick();
      expect_st("pz_dec", v, 1'b1, 1'b0, 1'b0);
    end
    tick();
    expect_st("pz_tc_edge9", 0, 1'b0, 1'b1, 1'b1);

    // 5a: stop at count 3
    tmr.load_val = 4'd8;
    tmr.start = 1'b1;
    tick();
    expect_st("m_8", 8, 1'b1, 1'b0, 1'b0);
    tmr.start = 1'b0;
    repeat (5) tick();
    expect_st("m_at3", 3, 1'b1, 1'b0, 1'b0);
    tmr.stop = 1'b1;
    tick();
    expect_st("m_stop", 0, 1'b0, 1'b0, 1'b0);
    tmr.stop = 1'b0;
    tick();
    expect_st("m_idle", 0, 1'b0, 1'b0, 1'b0);

    // 5b: restart with 2 at count 5
    tmr.start = 1'b1;
    tick();
    tmr.start = 1'b0;
    repeat (3) tick();
    expect_st("r_at5", 5, 1'b1, 1'b0, 1'b0);
    tmr.load_val = 4'd2;
    tmr.start = 1'b1;
    tick();
    expect_st("r_2", 2, 1'b1, 1'b0, 1'b0);
    tmr.start = 1'b0;
    tick();
    expect_st("r_1", 1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_st("r_tc", 0, 1'b0, 1'b1, 1'b1);

    // 5c: reset at count 4
    tmr.load_val = 4'd8;
    tmr.start = 1'b1;
    tick();
    tmr.start = 1'b0;
    repeat (4) tick();
    expect_st("x_at4", 4, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    expect_st("x_rst", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // 6: load 0, one-shot
    tmr.load_val = 4'd0;
    tmr.start = 1'b1;
    tick();
    expect_st("z_run", 0, 1'b1, 1'b0, 1'b0);
    tmr.start = 1'b0;
    tick();
    expect_st("z_tc", 0, 1'b0, 1'b1, 1'b1);
    tick();
    expect_st("z_done", 0, 1'b0, 1'b0, 1'b1);
    tmr.load_val = 4'd7;
    tmr.start = 1'b1;
    tmr.stop = 1'b1;
    tick();
    expect_st("z_stop_wins", 0, 1'b0, 1'b0, 1'b0);
    tmr.stop = 1'b0;

    // load 0 with auto-reload: tc every cycle
    tmr.load_val = 4'd0;
    tmr.auto_reload = 1'b1;
    tick();
    expect_st("za_run", 0, 1'b1, 1'b0, 1'b0);
    tmr.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_st("za_tc", 0, 1'b1, 1'b1, 1'b0);
    end

    // auto-reload 2 with a pause on the zero cycle, then auto_reload dropped
    tmr.load_val = 4'd2;
    tmr.start = 1'b1;
    tick();
    expect_st("ap_2", 2, 1'b1, 1'b0, 1'b0);
    tmr.start = 1'b0;
    tick();
    expect_st("ap_1", 1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_st("ap_tc", 0, 1'b1, 1'b1, 1'b0);
    tmr.pause = 1'b1;
    tick();
    expect_st("ap_pause0", 0, 1'b1, 1'b0, 1'b0);
    tmr.pause = 1'b0;
    tick();
    expect_st("ap_reload", 2, 1'b1, 1'b0, 1'b0);
    tick();
    expect_st("ap_1b", 1, 1'b1, 1'b0, 1'b0);
    tmr.auto_reload = 1'b0;
    tick();
    expect_st("ap_finish", 0, 1'b0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
